// File: rtl/i2c_pkg.sv
// Shared types for the byte-level I2C master: command opcodes, FSM states and
// the quarter-period phase of a bit slot.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_STOP  = 2'b11
  } I2cCmd;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StAckSlot,
    StStop,
    StResp
  } I2cState;

  typedef logic [1:0] i2c_phase_t;

  localparam i2c_phase_t Ph0 = 2'd0;
  localparam i2c_phase_t Ph1 = 2'd1;
  localparam i2c_phase_t Ph2 = 2'd2;
  localparam i2c_phase_t Ph3 = 2'd3;

  // Everything except START needs an open transaction on the bus.
  function automatic logic needs_bus(input I2cCmd op);
    return op != CMD_START;
  endfunction

  function automatic I2cState cmd_state(input I2cCmd op);
    unique case (op)
      CMD_START:           return StStart;
      CMD_WRITE, CMD_READ: return StData;
      default:             return StStop;
    endcase
  endfunction

endpackage

// File: rtl/i2c_byte_master_if.sv
// Command/response handshake plus open-drain pin pair of the I2C byte master.
// master = the engine's view, slave = the requester / board side.
interface i2c_byte_master_if;
  import i2c_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  I2cCmd      cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       rsp_err;
  logic       bus_active;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, cmd_nack, scl_i, sda_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_err, bus_active, scl_oe, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_nack, scl_i, sda_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, rsp_err, bus_active, scl_oe, sda_oe
  );

endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-SCL-period tick generator; clear realigns the count, hold freezes it
// at zero while a slave stretches SCL.
module i2c_clk_div #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(ClkDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    tick_o = 1'b0;
    if (clear_i || hold_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes START / WRITE / READ / STOP one at a time,
// each bit slot split into four divider phases, with SCL stretching support.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input logic                clk,
  input logic                rst,
  i2c_byte_master_if.master  ctrl_io
);

  I2cState    state_q, state_d;
  i2c_phase_t phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  I2cCmd      op_q, op_d;
  logic [7:0] shreg_q, shreg_d;
  logic       nack_cmd_q, nack_cmd_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_nack_q, rsp_nack_d;
  logic       rsp_err_q, rsp_err_d;
  logic       bus_active_q, bus_active_d;
  logic       scl_oe_q, scl_oe_d;
  logic       sda_oe_q, sda_oe_d;

  logic busy, accept, tick, stretch_hold;

  assign busy         = (state_q != StIdle) && (state_q != StResp);
  assign accept       = ctrl_io.cmd_valid && !busy;
  // SCL has been released but a slave is still holding it low.
  assign stretch_hold = busy && (phase_q == Ph1) && !ctrl_io.scl_i;

  i2c_clk_div #(
    .ClkDiv (CLK_DIV)
  ) u_clk_div (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (accept),
    .hold_i  (stretch_hold),
    .tick_o  (tick)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    op_d         = op_q;
    shreg_d      = shreg_q;
    nack_cmd_d   = nack_cmd_q;
    rsp_data_d   = rsp_data_q;
    rsp_nack_d   = rsp_nack_q;
    rsp_err_d    = rsp_err_q;
    bus_active_d = bus_active_q;
    scl_oe_d     = scl_oe_q;
    sda_oe_d     = sda_oe_q;

    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          op_d       = ctrl_io.cmd_op;
          shreg_d    = ctrl_io.cmd_data;
          nack_cmd_d = ctrl_io.cmd_nack;
          rsp_err_d  = 1'b0;
          phase_d    = Ph0;
          bit_cnt_d  = 3'd0;
          if (needs_bus(ctrl_io.cmd_op) && !bus_active_q) begin
            state_d   = StResp;
            rsp_err_d = 1'b1;
          end else begin
            state_d = cmd_state(ctrl_io.cmd_op);
          end
        end
      end
      StStart, StData, StAckSlot, StStop: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          case (state_q)
            StStart: begin
              if (phase_q == Ph3) begin
                bus_active_d = 1'b1;
                state_d      = StResp;
              end
            end
            StData: begin
              if (phase_q == Ph2) shreg_d = {shreg_q[6:0], ctrl_io.sda_i};
              if (phase_q == Ph3) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = StAckSlot;
              end
            end
            StAckSlot: begin
              if (phase_q == Ph2 && op_q == CMD_WRITE) rsp_nack_d = ctrl_io.sda_i;
              if (phase_q == Ph3) begin
                if (op_q == CMD_READ) rsp_data_d = shreg_q;
                state_d = StResp;
              end
            end
            default: begin
              if (phase_q == Ph3) begin
                bus_active_d = 1'b0;
                state_d      = StResp;
              end
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    // Pins are registered against the upcoming state/phase so they change
    // exactly on phase boundaries; IDLE/RESP keep whatever level was left.
    unique case (state_d)
      StStart: begin
        case (phase_d)
          Ph0:     sda_oe_d = 1'b0;
          Ph1:     scl_oe_d = 1'b0;
          Ph2:     sda_oe_d = 1'b1;
          default: scl_oe_d = 1'b1;
        endcase
      end
      StData: begin
        case (phase_d)
          Ph0: begin
            scl_oe_d = 1'b1;
            sda_oe_d = (op_d == CMD_WRITE) ? ~shreg_d[7] : 1'b0;
          end
          Ph1:     scl_oe_d = 1'b0;
          Ph3:     scl_oe_d = 1'b1;
          default: ;
        endcase
      end
      StAckSlot: begin
        case (phase_d)
          Ph0: begin
            scl_oe_d = 1'b1;
            sda_oe_d = (op_d == CMD_WRITE) ? 1'b0 : ~nack_cmd_d;
          end
          Ph1:     scl_oe_d = 1'b0;
          Ph3:     scl_oe_d = 1'b1;
          default: ;
        endcase
      end
      StStop: begin
        case (phase_d)
          Ph0: begin
            scl_oe_d = 1'b1;
            sda_oe_d = 1'b1;
          end
          Ph1:     scl_oe_d = 1'b0;
          Ph2:     sda_oe_d = 1'b0;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_q      <= Ph0;
      bit_cnt_q    <= 3'd0;
      op_q         <= CMD_START;
      shreg_q      <= 8'h00;
      nack_cmd_q   <= 1'b0;
      rsp_data_q   <= 8'h00;
      rsp_nack_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      bus_active_q <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      op_q         <= op_d;
      shreg_q      <= shreg_d;
      nack_cmd_q   <= nack_cmd_d;
      rsp_data_q   <= rsp_data_d;
      rsp_nack_q   <= rsp_nack_d;
      rsp_err_q    <= rsp_err_d;
      bus_active_q <= bus_active_d;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
    end
  end

  assign ctrl_io.cmd_ready  = !busy;
  assign ctrl_io.rsp_valid  = (state_q == StResp);
  assign ctrl_io.rsp_data   = rsp_data_q;
  assign ctrl_io.rsp_nack   = rsp_nack_q;
  assign ctrl_io.rsp_err    = rsp_err_q;
  assign ctrl_io.bus_active = bus_active_q;
  assign ctrl_io.scl_oe     = scl_oe_q;
  assign ctrl_io.sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: directed commands against a small I2C slave model,
// responses and SDA bit values checked from scoreboard queues.
module tb_i2c_byte_master;
  import i2c_pkg::*;

  localparam int unsigned ClkDiv = 4;
  localparam int LatShort = 4 * ClkDiv + 1;
  localparam int LatByte  = 36 * ClkDiv + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_byte_master_if ifc ();

  i2c_byte_master #(
    .CLK_DIV (ClkDiv)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Slave model: pulls SDA low for read data / ACK, stretches SCL on request.
  int         falls   = 0;
  logic       ack_en  = 1'b0;
  logic       rd_en   = 1'b0;
  logic       st_en   = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         st_cnt  = 0;
  logic       slv_low;
  logic       stretch;
  logic [2:0] bit_idx;

  assign stretch   = st_en && (falls == 2) && (st_cnt <= 10);
  assign ifc.scl_i = ~ifc.scl_oe & ~stretch;
  assign ifc.sda_i = ~ifc.sda_oe & ~slv_low;

  always_comb begin
    slv_low = 1'b0;
    bit_idx = 3'(7 - falls);
    if (rd_en && falls < 8) slv_low = ~rd_byte[bit_idx];
    if (ack_en && falls == 8) slv_low = 1'b1;
  end

  always @(negedge ifc.scl_i) falls = falls + 1;
  always @(negedge clk) if (stretch && !ifc.scl_oe) st_cnt = st_cnt + 1;

  // SDA bit scoreboard, sampled on every SCL rising edge while enabled.
  logic bit_q[$];
  logic bit_en = 1'b0;
  always @(posedge ifc.scl_i) begin
    if (bit_en) begin
      if (bit_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sda_bit_extra: got SCL rise with SDA=%0b required none", ifc.sda_i);
      end else begin
        check("sda_bit", 32'(ifc.sda_i), 32'(bit_q.pop_front()));
      end
    end
  end

  // Response scoreboard.
  typedef struct {
    string      name;
    logic       err;
    logic       nack;
    logic [7:0] data;
    int         acc;
    int         lat;
  } rsp_t;
  rsp_t rsp_q[$];
  int   n_rsp    = 0;
  logic prev_rsp = 1'b0;

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && ifc.rsp_valid) begin
      n_rsp++;
      check("rsp_valid_one_cycle", 32'(prev_rsp), 32'd0);
      if (rsp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 required no response");
      end else begin
        e = rsp_q.pop_front();
        check({e.name, " rsp_err"}, 32'(ifc.rsp_err), 32'(e.err));
        check({e.name, " rsp_nack"}, 32'(ifc.rsp_nack), 32'(e.nack));
        check({e.name, " rsp_data"}, 32'(ifc.rsp_data), 32'(e.data));
        check({e.name, " cmd_ready"}, 32'(ifc.cmd_ready), 32'd1);
        check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    prev_rsp = ifc.rsp_valid && !rst;
  end

  logic pin_watch = 1'b0;
  logic pin_bad   = 1'b0;
  always @(negedge clk) if (pin_watch && (ifc.scl_oe || ifc.sda_oe)) pin_bad = 1'b1;

  logic [7:0] m_data = 8'h00;
  logic       m_nack = 1'b0;

  task automatic issue(input string name, input I2cCmd op, input logic [7:0] data,
                       input logic nack, input logic e_err, input int lat);
    rsp_t e;
    int   n = 0;
    @(negedge clk);
    while (!ifc.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s cmd_ready_timeout: got cmd_ready=0 required 1", name);
    end
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = data;
    ifc.cmd_nack  = nack;
    e.name = name;
    e.err  = e_err;
    e.nack = m_nack;
    e.data = m_data;
    e.acc  = cyc + 1;
    e.lat  = lat;
    rsp_q.push_back(e);
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (rsp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s rsp_timeout: got no rsp_valid required one", name);
      rsp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic ack_bit);
    for (int i = 7; i >= 0; i--) bit_q.push_back(b[i]);
    bit_q.push_back(ack_bit);
  endtask

  initial begin
    int n;
    int base;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = CMD_START;
    ifc.cmd_data  = 8'h00;
    ifc.cmd_nack  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset scl_oe", 32'(ifc.scl_oe), 32'd0);
    check("reset sda_oe", 32'(ifc.sda_oe), 32'd0);
    check("reset cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("reset rsp_data", 32'(ifc.rsp_data), 32'd0);
    check("reset rsp_nack", 32'(ifc.rsp_nack), 32'd0);
    check("reset rsp_err", 32'(ifc.rsp_err), 32'd0);
    check("reset bus_active", 32'(ifc.bus_active), 32'd0);
    rst = 1'b0;

    // WRITE with no open transaction is rejected without touching the pins.
    pin_watch = 1'b1;
    issue("err_write", CMD_WRITE, 8'h12, 1'b0, 1'b1, 1);
    wait_done("err_write");
    repeat (20) @(negedge clk);
    pin_watch = 1'b0;
    check("err_write pins_idle", 32'(pin_bad), 32'd0);
    check("err_write bus_active", 32'(ifc.bus_active), 32'd0);

    // START, then WRITE 0xA1 acknowledged by the slave.
    issue("start1", CMD_START, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("start1");
    check("start1 bus_active", 32'(ifc.bus_active), 32'd1);
    falls  = 0;
    ack_en = 1'b1;
    push_byte(8'hA1, 1'b0);
    bit_en = 1'b1;
    issue("write_a1", CMD_WRITE, 8'hA1, 1'b0, 1'b0, LatByte);
    wait_done("write_a1");
    bit_en = 1'b0;
    ack_en = 1'b0;
    check("write_a1 bits_left", 32'(bit_q.size()), 32'd0);
    check("write_a1 scl_held", 32'(ifc.scl_oe), 32'd1);
    check("write_a1 sda_released", 32'(ifc.sda_oe), 32'd0);
    check("write_a1 bus_active", 32'(ifc.bus_active), 32'd1);

    // READ 0x5C with master NACK, then STOP.
    falls   = 0;
    rd_byte = 8'h5C;
    rd_en   = 1'b1;
    push_byte(8'h5C, 1'b1);
    bit_en  = 1'b1;
    m_data  = 8'h5C;
    issue("read_5c", CMD_READ, 8'h00, 1'b1, 1'b0, LatByte);
    wait_done("read_5c");
    bit_en = 1'b0;
    rd_en  = 1'b0;
    check("read_5c bits_left", 32'(bit_q.size()), 32'd0);
    check("read_5c scl_held", 32'(ifc.scl_oe), 32'd1);
    check("read_5c sda_nack", 32'(ifc.sda_oe), 32'd0);
    issue("stop1", CMD_STOP, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("stop1");
    check("stop1 bus_active", 32'(ifc.bus_active), 32'd0);
    check("stop1 scl_oe", 32'(ifc.scl_oe), 32'd0);
    check("stop1 sda_oe", 32'(ifc.sda_oe), 32'd0);

    // WRITE 0x50 with nobody answering: NACK, no error.
    issue("start2", CMD_START, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("start2");
    m_nack = 1'b1;
    issue("write_50", CMD_WRITE, 8'h50, 1'b0, 1'b0, LatByte);
    wait_done("write_50");
    issue("stop2", CMD_STOP, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("stop2");

    // READ 0x3A with a 10-cycle stretch in slot 3, master ACKs.
    issue("start3", CMD_START, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("start3");
    falls   = 0;
    st_cnt  = 0;
    st_en   = 1'b1;
    rd_byte = 8'h3A;
    rd_en   = 1'b1;
    m_data  = 8'h3A;
    issue("read_stretch", CMD_READ, 8'h00, 1'b0, 1'b0, LatByte + 10);
    wait_done("read_stretch");
    rd_en = 1'b0;
    st_en = 1'b0;
    check("read_stretch cycles", 32'(st_cnt), 32'd11);
    check("read_stretch sda_ack", 32'(ifc.sda_oe), 32'd1);
    issue("stop3", CMD_STOP, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("stop3");

    // Reset in the middle of a WRITE (slot 4, phase 0).
    issue("start4", CMD_START, 8'h00, 1'b0, 1'b0, LatShort);
    wait_done("start4");
    falls  = 0;
    ack_en = 1'b1;
    issue("write_abort", CMD_WRITE, 8'hA1, 1'b0, 1'b0, LatByte);
    n = 0;
    while (falls != 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort reach_slot4", 32'(falls), 32'd3);
    repeat (4) @(negedge clk);
    check("abort pre scl_oe", 32'(ifc.scl_oe), 32'd1);
    check("abort pre sda_oe", 32'(ifc.sda_oe), 32'd1);
    rst = 1'b1;
    rsp_q.delete();
    ack_en = 1'b0;
    base   = n_rsp;
    #1;
    check("abort scl_oe", 32'(ifc.scl_oe), 32'd0);
    check("abort sda_oe", 32'(ifc.sda_oe), 32'd0);
    repeat (3) @(negedge clk);
    check("abort cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort no_rsp", 32'(n_rsp - base), 32'd0);
    check("abort bus_active", 32'(ifc.bus_active), 32'd0);
    check("abort rsp_data", 32'(ifc.rsp_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
